sw_debounce: RTL and testbench
==============================

# sw_debounce

Board-level input conditioner for slide switches and push-buttons, the input-side counterpart of our switch-to-LED output paths. Each raw, asynchronous, bouncing pad input is synchronised into `clk`, filtered by a per-channel stability counter and state machine, and presented as:
- a clean level;
- single-cycle rise and fall pulses;
- a press-toggled state suitable for driving an LED directly.

## Interface
- `WIDTH`, 1: number of independent switch channels.
- `STABLE_CYCLES`, 1_000_000: consecutive stable samples needed to accept a change (10 ms at 100 MHz); legal range ≥ 2.

Ports:
- `clk`  in  1: system clock; every register is in this single clock domain.
- `rst`  in  1: reset, synchronous and active-high.
- `sw`  in  WIDTH: raw pad inputs, asynchronous to `clk`.
- `sw_level`  out  WIDTH: debounced level.
- `sw_rise`  out  WIDTH: one-cycle pulse when `sw_level` goes 0→1.
- `sw_fall`  out  WIDTH: one-cycle pulse when `sw_level` goes 1→0.
- `sw_toggle`  out  WIDTH: inverts on every `sw_rise`.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Reset also clears both synchroniser stages, the counter (0) and the state (`IDLE_LO`).
- Per channel, the input path is:
  - a 2-flop synchroniser `sw` → `s`;
  - a counter of width `$clog2(STABLE_CYCLES)`;
  - a 4-state FSM.
- FSM states and transitions:
  - `IDLE_LO`: if `s`=1, go to `WAIT_HI` with cnt=0; otherwise stay.
  - `WAIT_HI`:
    - if `s`=0, return to `IDLE_LO` and set cnt=0 (bounce rejected, no output change);
    - else if cnt==`STABLE_CYCLES`-1, go to `IDLE_HI`, set `sw_level`=1, pulse `sw_rise`, invert `sw_toggle`;
    - else cnt+1.
  - `IDLE_HI`: if `s`=0, go to `WAIT_LO` with cnt=0.
  - `WAIT_LO`: mirror image of `WAIT_HI`. On acceptance, go to `IDLE_LO`, set `sw_level`=0, pulse `sw_fall`. `sw_toggle` is unchanged.
- Rise and fall pulses last exactly one cycle and are never asserted together on a channel.
- Counter never wraps. It is cleared on every state entry and saturates by the transition.
- Channels are fully independent. Simultaneous events on different channels are reported in the same cycle.
- Switch held high through reset: after reset release the input is treated as a fresh rise. `sw_rise` pulses and `sw_toggle` becomes 1 after the normal latency.
- `rst` asserted mid-`WAIT_*`: the pending change is discarded, and all outputs are 0 on the following edge.

## Timing
- Synchroniser latency is 2 edges. The FSM first sees a new value on edge 3 after the pad change.
- Accept latency: `sw_level`/`sw_rise` update on edge `STABLE_CYCLES`+3 after a clean pad change. This requires `s` to be stable for `STABLE_CYCLES`+1 consecutive FSM samples.
- Any pulse on `s` shorter than `STABLE_CYCLES`+1 cycles produces no output activity.
- Minimum spacing between accepted events on one channel is `STABLE_CYCLES`+1 cycles.
- No combinational path from `sw` to any output.

## Structure
- Package `sw_debounce_pkg`:
  - 2-bit state encodings `IDLE_LO`=0, `WAIT_HI`=1, `IDLE_HI`=2, `WAIT_LO`=3;
  - default `STABLE_CYCLES` constant.
- Sub-module `sw_debounce_ch`: one channel, containing the synchroniser, counter and FSM, with 1-bit ports mirroring the top.
- Top `sw_debounce` is a generate loop of `WIDTH` instances of `sw_debounce_ch` only; no other logic.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `WIDTH`=2 unless noted.
1. Reset with `sw`=00 held 10 cycles → all outputs 00 throughout and after release.
2. `sw[0]` 0→1 clean before edge 0 → `sw_level[0]`=1 and `sw_rise[0]`=1 at edge 7 only; `sw_toggle[0]`=1; channel 1 silent.
3. `sw[0]` bounces 1,0,1,0 with 2-cycle phases, then holds 1 → exactly one `sw_rise[0]`, 7 edges after the final transition; no `sw_fall`.
4. `sw[1]` high for 3 cycles from idle, then low → no `sw_level`, `sw_rise` or `sw_fall` activity.
5. Release from test 2 (1→0) → `sw_fall[0]` at +7 and `sw_toggle[0]` stays 1. A second press → `sw_toggle[0]` returns to 0. Both channels pressed on the same edge → both `sw_rise` bits assert in the same cycle.
6. `rst` asserted at edge 5 of a rising acceptance → all outputs 0 from edge 6. `sw` held 1 through release → rise accepted 7 edges after release.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared FSM state encoding and default filter length for the switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // 10 ms at 100 MHz
  localparam int DEF_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stability counter and 4-state
// acceptance FSM driving registered level / rise / fall / toggle outputs.
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_toggle
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             toggle_nxt;

  // Stage p0/p1: bring the asynchronous pad into clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // Filter stage: FSM samples the synchronised value; outputs registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_LO;
      cnt       <= '0;
      sw_level  <= 1'b0;
      sw_rise   <= 1'b0;
      sw_fall   <= 1'b0;
      sw_toggle <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sw_level  <= level_nxt;
      sw_rise   <= rise_nxt;
      sw_fall   <= fall_nxt;
      sw_toggle <= toggle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    level_nxt  = sw_level;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    toggle_nxt = sw_toggle;
    case (state)
      IDLE_LO: begin
        if (sync_p1) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_p1) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = IDLE_HI;
          cnt_nxt    = '0;
          level_nxt  = 1'b1;
          rise_nxt   = 1'b1;
          toggle_nxt = ~sw_toggle;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!sync_p1) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_p1) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: WIDTH independent sw_debounce_ch instances.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_toggle
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sw_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw[i]),
      .sw_level (sw_level[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .sw_toggle(sw_toggle[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed plus randomized bench for sw_debounce against a run-length
// reference model of the debounce acceptance rule.
module tb_sw_debounce;

  localparam int W = 2;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw  = '0;
  logic [W-1:0] sw_level;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic [W-1:0] sw_toggle;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH(W),
    .STABLE_CYCLES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_toggle(sw_toggle)
  );

  // Reference: a change is accepted once the synchronised input has differed
  // from the accepted level for S+1 consecutive samples.
  logic [W-1:0] m_level  = '0;
  logic [W-1:0] m_rise   = '0;
  logic [W-1:0] m_fall   = '0;
  logic [W-1:0] m_toggle = '0;
  logic [W-1:0] pad_ago1 = '0;
  logic [W-1:0] pad_ago2 = '0;
  int           run [W];

  int n_checks = 0;
  int n_fails  = 0;
  int ch1_act  = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] seen;
    seen = pad_ago2;
    if (rst) begin
      m_level  = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_toggle = '0;
      pad_ago1 = '0;
      pad_ago2 = '0;
      for (int c = 0; c < W; c++) run[c] = 0;
    end else begin
      m_rise   = '0;
      m_fall   = '0;
      pad_ago2 = pad_ago1;
      pad_ago1 = sw;
      for (int c = 0; c < W; c++) begin
        if (seen[c] != m_level[c]) begin
          run[c]++;
          if (run[c] == S + 1) begin
            run[c]     = 0;
            m_level[c] = seen[c];
            if (seen[c]) begin
              m_rise[c]   = 1'b1;
              m_toggle[c] = ~m_toggle[c];
            end else begin
              m_fall[c] = 1'b1;
            end
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [W-1:0] s_in, input logic r_in);
    @(negedge clk);
    sw  = s_in;
    rst = r_in;
    @(posedge clk);
    model_edge();
    #1;
    check("level", sw_level, m_level);
    check("rise", sw_rise, m_rise);
    check("fall", sw_fall, m_fall);
    check("toggle", sw_toggle, m_toggle);
    check("rise_fall_excl", sw_rise & sw_fall, '0);
    if (sw_level[1] | sw_rise[1] | sw_fall[1]) ch1_act++;
  endtask

  task automatic hold(input logic [W-1:0] s_in, input logic r_in, input int n);
    for (int i = 0; i < n; i++) step(s_in, r_in);
  endtask

  initial begin
    logic [W-1:0] rs;
    for (int c = 0; c < W; c++) run[c] = 0;

    // 1: reset with switches low
    hold(2'b00, 1'b1, 10);
    check("t1_reset_outs", sw_level | sw_rise | sw_fall | sw_toggle, 2'b00);
    hold(2'b00, 1'b0, 5);

    // 2: clean press on channel 0, rise on edge 7
    for (int i = 0; i < 10; i++) begin
      step(2'b01, 1'b0);
      if (i == 5) check("t2_no_early_rise", sw_rise, 2'b00);
      if (i == 6) check("t2_rise_edge7", sw_rise, 2'b01);
    end
    check("t2_toggle", sw_toggle, 2'b01);
    check("t2_level", sw_level, 2'b01);

    // 5a: release, fall on edge 7, toggle unchanged
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 1'b0);
      if (i == 6) check("t5_fall_edge7", sw_fall, 2'b01);
    end
    check("t5_toggle_kept", sw_toggle, 2'b01);

    // 3: bouncing press, single rise 7 edges after final transition
    for (int b = 0; b < 2; b++) begin
      hold(2'b01, 1'b0, 2);
      hold(2'b00, 1'b0, 2);
    end
    for (int i = 0; i < 12; i++) begin
      step(2'b01, 1'b0);
      if (i == 6) check("t3_rise_after_bounce", sw_rise, 2'b01);
    end
    check("t3_toggle_back", sw_toggle, 2'b00);
    hold(2'b00, 1'b0, 10);

    // 4: short glitch on channel 1 is rejected
    ch1_act = 0;
    hold(2'b10, 1'b0, 3);
    hold(2'b00, 1'b0, 10);
    check("t4_ch1_quiet", (ch1_act != 0) ? 2'b01 : 2'b00, 2'b00);

    // 5c: both channels pressed on the same edge
    for (int i = 0; i < 10; i++) begin
      step(2'b11, 1'b0);
      if (i == 6) check("t5_both_rise", sw_rise, 2'b11);
    end
    hold(2'b00, 1'b0, 10);

    // 6: reset in the middle of an acceptance, switch held through release
    hold(2'b01, 1'b0, 4);
    step(2'b01, 1'b1);
    check("t6_reset_outs", sw_level | sw_rise | sw_fall | sw_toggle, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step(2'b01, 1'b0);
      if (i == 6) check("t6_rise_after_rst", sw_rise, 2'b01);
    end
    check("t6_toggle", sw_toggle, 2'b01);

    // Randomized bouncing with occasional resets
    rs = 2'b01;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 5) == 0) rs[c] = ~rs[c];
      step(rs, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
